// File: rtl/sound_pkg.sv
// Shared types and defaults for the sound generator / measurement blocks.
package sound_pkg;

  localparam int PERIOD_W_DEFAULT = 32;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } period_state_t;

endpackage

// File: rtl/period_detector_if.sv
// Sample-stream in / period-report out bundle for period_detector.
interface period_detector_if
  import sound_pkg::*;
#(
  parameter int SAMPLE_W = 32,
  parameter int PERIOD_W = PERIOD_W_DEFAULT
);

  logic                       sample_en;
  logic signed [SAMPLE_W-1:0] sample;
  logic        [PERIOD_W-1:0] period;
  logic                       period_valid;
  logic                       locked;
  logic                       timeout;

  modport master (
    output sample_en, sample,
    input  period, period_valid, locked, timeout
  );

  modport slave (
    input  sample_en, sample,
    output period, period_valid, locked, timeout
  );

endinterface

// File: rtl/zero_cross_detect.sv
// Rising zero-crossing detector with symmetric hysteresis; emits a one-sample
// crossing strobe once the signal has dipped below -HYST and risen to +HYST.
module zero_cross_detect #(
  parameter int SAMPLE_W = 32,
  parameter int HYST     = 64
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_sample_en,
  input  logic signed [SAMPLE_W-1:0] i_sample,
  input  logic                       i_clear,
  output logic                       o_crossing
);

  localparam logic signed [SAMPLE_W-1:0] HYST_POS = SAMPLE_W'(HYST);
  localparam logic signed [SAMPLE_W-1:0] HYST_NEG = -HYST_POS;

  logic r_armed;
  logic w_below;
  logic w_above;

  assign w_below    = i_sample < HYST_NEG;
  assign w_above    = i_sample >= HYST_POS;
  assign o_crossing = i_sample_en && r_armed && w_above;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_armed <= 1'b0;
    end else if (i_clear) begin
      r_armed <= 1'b0;
    end else if (o_crossing) begin
      r_armed <= 1'b0;
    end else if (i_sample_en && w_below) begin
      r_armed <= 1'b1;
    end
  end

endmodule

// File: rtl/period_detector.sv
// Measures waveform period in enabled samples between rising crossings.
// Define PERIOD_DETECTOR_AVG_EN to report the mean of every 4 measurements.
module period_detector
  import sound_pkg::*;
#(
  parameter int SAMPLE_W   = 32,
  parameter int PERIOD_W   = PERIOD_W_DEFAULT,
  parameter int HYST       = 64,
  parameter int MAX_PERIOD = 1 << 24
) (
  input logic               clk,
  input logic               reset_n,
  period_detector_if.slave  bus
);

  localparam logic [PERIOD_W-1:0] COUNT_LAST = PERIOD_W'(MAX_PERIOD - 1);

  period_state_t       r_state, w_state_next;
  logic [PERIOD_W-1:0] r_count, w_count_next;
  logic [PERIOD_W-1:0] r_period, w_period_next;
  logic                r_period_valid, w_period_valid_next;
  logic                r_locked, w_locked_next;
  logic                r_timeout, w_timeout_next;
  logic                w_crossing;
  logic                w_measure;
  logic                w_lost;

`ifdef PERIOD_DETECTOR_AVG_EN
  logic [PERIOD_W+1:0] r_acc, w_acc_next;
  logic [1:0]          r_idx, w_idx_next;
  logic [PERIOD_W+1:0] w_sum;
`endif

  zero_cross_detect #(
    .SAMPLE_W (SAMPLE_W),
    .HYST     (HYST)
  ) u_zero_cross (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_sample_en (bus.sample_en),
    .i_sample    (bus.sample),
    .i_clear     (w_lost),
    .o_crossing  (w_crossing)
  );

  // NOTE: every signal gets a default before any branch so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next        = r_state;
    w_count_next        = r_count;
    w_period_next       = r_period;
    w_period_valid_next = 1'b0;
    w_locked_next       = r_locked;
    w_timeout_next      = 1'b0;
    w_measure           = 1'b0;
    w_lost              = 1'b0;

    if (bus.sample_en) begin
      case (r_state)
        SEARCH: begin
          if (w_crossing) begin
            w_count_next = PERIOD_W'(1);
            w_state_next = LOCKED;
          end
        end
        LOCKED: begin
          // A crossing on the final count still counts as a measurement.
          if (w_crossing) begin
            w_measure     = 1'b1;
            w_locked_next = 1'b1;
            w_count_next  = PERIOD_W'(1);
          end else if (r_count == COUNT_LAST) begin
            w_lost         = 1'b1;
            w_period_next  = '0;
            w_locked_next  = 1'b0;
            w_timeout_next = 1'b1;
            w_count_next   = '0;
            w_state_next   = SEARCH;
          end else begin
            w_count_next = r_count + PERIOD_W'(1);
          end
        end
        default: w_state_next = SEARCH;
      endcase
    end

`ifdef PERIOD_DETECTOR_AVG_EN
    w_acc_next = r_acc;
    w_idx_next = r_idx;
    w_sum      = r_acc + (PERIOD_W+2)'(r_count);
    if (w_lost) begin
      w_acc_next = '0;
      w_idx_next = '0;
    end else if (w_measure) begin
      if (r_idx == 2'd3) begin
        w_period_next       = w_sum[PERIOD_W+1:2];
        w_period_valid_next = 1'b1;
        w_acc_next          = '0;
        w_idx_next          = '0;
      end else begin
        w_acc_next = w_sum;
        w_idx_next = r_idx + 2'd1;
      end
    end
`else
    if (w_measure) begin
      w_period_next       = r_count;
      w_period_valid_next = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= SEARCH;
      r_count        <= '0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_locked       <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_count        <= w_count_next;
      r_period       <= w_period_next;
      r_period_valid <= w_period_valid_next;
      r_locked       <= w_locked_next;
      r_timeout      <= w_timeout_next;
    end
  end

`ifdef PERIOD_DETECTOR_AVG_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= '0;
      r_idx <= '0;
    end else begin
      r_acc <= w_acc_next;
      r_idx <= w_idx_next;
    end
  end
`endif

  assign bus.period       = r_period;
  assign bus.period_valid = r_period_valid;
  assign bus.locked       = r_locked;
  assign bus.timeout      = r_timeout;

endmodule
